// File: rtl/text_pkg.sv
// Shared constants, character codes, FSM states and word helpers for the text console.
package text_pkg;

   localparam int unsigned WORD      = 32;
   localparam int unsigned BYTE_CNT  = 4;
   localparam int unsigned ADDRW     = 11;
   localparam int unsigned TRAM_HRES = 84;
   localparam int unsigned TRAM_VRES = 24;
   localparam int unsigned CIDXW     = 4;
   localparam int unsigned N         = TRAM_HRES * TRAM_VRES;
   localparam int unsigned COLW      = 7;
   localparam int unsigned ROWW      = 5;

   // tram word field positions
   localparam int unsigned FG_MSB    = 31;
   localparam int unsigned BG_MSB    = 27;
   localparam int unsigned CODE_MSB  = 7;

   localparam logic [7:0] CH_BS       = 8'h08;
   localparam logic [7:0] CH_LF       = 8'h0A;
   localparam logic [7:0] CH_CR       = 8'h0D;
   localparam logic [7:0] CH_SPACE    = 8'h20;
   localparam logic [7:0] CH_PRINT_LO = 8'h20;
   localparam logic [7:0] CH_PRINT_HI = 8'h7E;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CLEAR_LINE,
      ST_CLEAR_ALL
   } state_t;

   // Assemble a tram word from colour indices and character code.
   function automatic logic [WORD-1:0] tram_word(input logic [CIDXW-1:0] fg,
                                                 input logic [CIDXW-1:0] bg,
                                                 input logic [7:0]       code);
      logic [WORD-1:0] w;
      w = '0;
      w[FG_MSB -: CIDXW] = fg;
      w[BG_MSB -: CIDXW] = bg;
      w[CODE_MSB:0]      = code;
      return w;
   endfunction

   // Add two in-range addresses and fold the result back into 0..N-1.
   function automatic logic [ADDRW-1:0] addr_add(input logic [ADDRW-1:0] a,
                                                 input logic [ADDRW-1:0] b);
      logic [ADDRW:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= (ADDRW+1)'(N)) s = s - (ADDRW+1)'(N);
      return s[ADDRW-1:0];
   endfunction

endpackage

// File: rtl/text_console.sv
// Writer side of the text RAM: turns a character stream into tram word writes,
// tracks the cursor and scrolls by moving scroll_offs and blanking the new bottom line.
module text_console
   import text_pkg::*;
(
   input  logic                clk_sys,
   input  logic                rst_sys,
   input  logic                char_valid,
   output logic                char_ready,
   input  logic [7:0]          char_data,
   input  logic [CIDXW-1:0]    colr_fg,
   input  logic [CIDXW-1:0]    colr_bg,
   input  logic                clear,
   output logic                busy,
   output logic [BYTE_CNT-1:0] tram_we,
   output logic [ADDRW-1:0]    tram_addr,
   output logic [WORD-1:0]     tram_din,
   output logic [ADDRW-1:0]    scroll_offs,
   output logic [COLW-1:0]     cur_col,
   output logic [ROWW-1:0]     cur_row
);

   localparam logic [COLW-1:0]  COL_LAST  = COLW'(TRAM_HRES - 1);
   localparam logic [ROWW-1:0]  ROW_LAST  = ROWW'(TRAM_VRES - 1);
   localparam logic [ADDRW-1:0] LINE_LAST = ADDRW'(TRAM_HRES - 1);
   localparam logic [ADDRW-1:0] SCR_LAST  = ADDRW'(N - 1);
   localparam logic [ADDRW-1:0] LINE_LEN  = ADDRW'(TRAM_HRES);

   state_t              state;
   logic [ADDRW-1:0]    line_base;
   logic [ADDRW-1:0]    cnt;
   logic [CIDXW-1:0]    fg_q;
   logic [CIDXW-1:0]    bg_q;

   logic                accept;
   logic                printable;
   logic                adv_row;

   // Handshake and character classification.
   assign char_ready = (state == ST_IDLE) && !clear && !rst_sys;
   assign accept     = char_valid && char_ready;
   assign printable  = (char_data >= CH_PRINT_LO) && (char_data <= CH_PRINT_HI);
   assign adv_row    = accept && ((char_data == CH_LF) || (printable && (cur_col == COL_LAST)));

   // Cursor, scroll and blanking state machine with registered tram port.
   always_ff @(posedge clk_sys) begin
      if (rst_sys) begin
         state       <= ST_IDLE;
         busy        <= 1'b0;
         tram_we     <= '0;
         tram_addr   <= '0;
         tram_din    <= '0;
         scroll_offs <= '0;
         line_base   <= '0;
         cur_col     <= '0;
         cur_row     <= '0;
         cnt         <= '0;
         fg_q        <= '0;
         bg_q        <= '0;
      end else begin
         tram_we <= '0;
         if (clear) begin
            state       <= ST_CLEAR_ALL;
            busy        <= 1'b1;
            cnt         <= '0;
            cur_col     <= '0;
            cur_row     <= '0;
            scroll_offs <= '0;
            line_base   <= '0;
            fg_q        <= colr_fg;
            bg_q        <= colr_bg;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (accept) begin
                     fg_q <= colr_fg;
                     bg_q <= colr_bg;
                     if (printable) begin
                        tram_we   <= '1;
                        tram_addr <= addr_add(line_base, ADDRW'(cur_col));
                        tram_din  <= tram_word(colr_fg, colr_bg, char_data);
                        cur_col   <= (cur_col == COL_LAST) ? '0 : cur_col + COLW'(1);
                     end else if ((char_data == CH_LF) || (char_data == CH_CR)) begin
                        cur_col <= '0;
                     end else if (char_data == CH_BS) begin
                        if (cur_col != '0) begin
                           cur_col   <= cur_col - COLW'(1);
                           tram_we   <= '1;
                           tram_addr <= addr_add(line_base, ADDRW'(cur_col - COLW'(1)));
                           tram_din  <= tram_word(colr_fg, colr_bg, CH_SPACE);
                        end
                     end
                  end
                  // Line advance: move down, or scroll and blank the line that becomes the bottom.
                  if (adv_row) begin
                     if (cur_row < ROW_LAST) begin
                        cur_row   <= cur_row + ROWW'(1);
                        line_base <= addr_add(line_base, LINE_LEN);
                     end else begin
                        scroll_offs <= addr_add(scroll_offs, LINE_LEN);
                        line_base   <= scroll_offs;
                        cnt         <= '0;
                        busy        <= 1'b1;
                        state       <= ST_CLEAR_LINE;
                     end
                  end
               end
               ST_CLEAR_LINE: begin
                  tram_we   <= '1;
                  tram_addr <= addr_add(line_base, cnt);
                  tram_din  <= tram_word(fg_q, bg_q, CH_SPACE);
                  if (cnt == LINE_LAST) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     cnt <= cnt + ADDRW'(1);
                  end
               end
               ST_CLEAR_ALL: begin
                  tram_we   <= '1;
                  tram_addr <= cnt;
                  tram_din  <= tram_word(fg_q, bg_q, CH_SPACE);
                  if (cnt == SCR_LAST) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     cnt <= cnt + ADDRW'(1);
                  end
               end
               default: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
